mandelbrot_dispatcher: RTL

Frame-level scheduler that sweeps the MAX_X × MAX_Y pixel grid in raster order and generates the fixed-point complex coordinate for each pixel. It shares the pixels across NUM_CORES Mandelbrot calculator cores, collects each core's colour result, and writes the result to the frame buffer at the pixel's linear address. It replaces the free-running start/address-mapper pairing and owns all core sequencing for one frame per request.

---
 rtl/mandelbrot_dispatcher.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/mandelbrot_dispatcher.sv
// Frame scheduler: sweeps the pixel grid in raster order, shares pixels across the
// calculator cores, and writes each colour result to the frame buffer at y*MAX_X+x.

module mandelbrot_dispatcher #(
   parameter int unsigned          BIT_WIDTH       = 32,
   parameter int unsigned          FLOAT_PRECISION = 24,
   parameter int unsigned          MAX_X           = 64,
   parameter int unsigned          MAX_Y           = 48,
   parameter int unsigned          NUM_CORES       = 4,
   parameter int unsigned          ADDR_WIDTH      = 12,
   parameter logic [BIT_WIDTH-1:0] X_START         = 32'hFE000000,
   parameter logic [BIT_WIDTH-1:0] X_STEP          = 32'h00040000,
   parameter logic [BIT_WIDTH-1:0] Y_START         = 32'hFF000000,
   parameter logic [BIT_WIDTH-1:0] Y_STEP          = 32'h00040000
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           frame_start,
   output logic                           frame_busy,
   output logic                           frame_done,
   output logic [NUM_CORES-1:0]           core_start,
   output logic [NUM_CORES*BIT_WIDTH-1:0] core_real,
   output logic [NUM_CORES*BIT_WIDTH-1:0] core_imag,
   input  logic [NUM_CORES-1:0]           core_ready_for_input,
   input  logic [NUM_CORES-1:0]           core_out_ready,
   input  logic [NUM_CORES*BIT_WIDTH-1:0] core_colour,
   output logic                           fb_wr_en,
   output logic [ADDR_WIDTH-1:0]          fb_wr_addr,
   output logic [BIT_WIDTH-1:0]           fb_wr_data,
   input  logic                           fb_wr_ready
);

   localparam int unsigned XW = (MAX_X > 1) ? $clog2(MAX_X) : 1;
   localparam int unsigned YW = (MAX_Y > 1) ? $clog2(MAX_Y) : 1;
   localparam int unsigned CW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
   localparam logic [XW-1:0] X_LAST = XW'(MAX_X - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(MAX_Y - 1);
   localparam logic [CW-1:0] C_LAST = CW'(NUM_CORES - 1);

   if (FLOAT_PRECISION >= BIT_WIDTH || NUM_CORES < 1 || NUM_CORES > 8 ||
       MAX_X * MAX_Y > 2 ** ADDR_WIDTH) begin : g_bad_params
      $error("mandelbrot_dispatcher: illegal parameter combination");
   end

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
   typedef enum logic [1:0] {SLOT_FREE, SLOT_BUSY, SLOT_RESULT} slot_t;

   state_t                  state, state_nxt;
   logic [XW-1:0]           x;
   logic [YW-1:0]           y;
   logic [ADDR_WIDTH-1:0]   addr;
   logic [BIT_WIDTH-1:0]    re, im;

   slot_t                   slot_st     [NUM_CORES];
   logic [ADDR_WIDTH-1:0]   slot_addr   [NUM_CORES];
   logic [BIT_WIDTH-1:0]    slot_re     [NUM_CORES];
   logic [BIT_WIDTH-1:0]    slot_im     [NUM_CORES];
   logic [BIT_WIDTH-1:0]    slot_colour [NUM_CORES];
   logic [1:0]              slot_hold   [NUM_CORES];

   logic                    disp_ok;
   logic [CW-1:0]           disp_idx;
   logic                    last_pixel;
   logic                    all_free;

   logic [CW-1:0]           rr_ptr;
   logic                    rr_ok;
   logic [CW-1:0]           rr_idx;
   logic [CW-1:0]           jj;
   logic                    wr_lock;
   logic [CW-1:0]           wr_sel;
   logic [CW-1:0]           sel;
   logic                    wr_valid;
   logic                    wr_done;

   // Dispatch target: lowest-index free slot whose core can take a start.
   always_comb begin
      disp_ok  = 1'b0;
      disp_idx = '0;
      all_free = 1'b1;
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
         if (slot_st[i] != SLOT_FREE) all_free = 1'b0;
         if (state == S_RUN && !disp_ok && slot_st[i] == SLOT_FREE &&
             core_ready_for_input[i]) begin
            disp_ok  = 1'b1;
            disp_idx = CW'(i);
         end
      end
   end

   assign last_pixel = (x == X_LAST) && (y == Y_LAST);

   // Once a write is presented it is locked until accepted, so a newly arriving
   // result can never change the address/data under a stalled write.
   always_comb begin
      rr_ok  = 1'b0;
      rr_idx = '0;
      jj     = '0;
      for (int unsigned k = 0; k < NUM_CORES; k++) begin
         jj = CW'((32'(rr_ptr) + k) % NUM_CORES);
         if (!rr_ok && slot_st[jj] == SLOT_RESULT) begin
            rr_ok  = 1'b1;
            rr_idx = jj;
         end
      end
      sel        = wr_lock ? wr_sel : rr_idx;
      wr_valid   = wr_lock | rr_ok;
      wr_done    = wr_valid & fb_wr_ready;
      fb_wr_en   = wr_valid;
      fb_wr_addr = wr_valid ? slot_addr[sel]   : '0;
      fb_wr_data = wr_valid ? slot_colour[sel] : '0;
   end

   always_comb begin
      core_real = '0;
      core_imag = '0;
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
         core_real[i*BIT_WIDTH +: BIT_WIDTH] = slot_re[i];
         core_imag[i*BIT_WIDTH +: BIT_WIDTH] = slot_im[i];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      frame_busy = (state != S_IDLE);
      frame_done = (state == S_DONE);
      case (state)
         S_IDLE:  if (frame_start) state_nxt = S_RUN;
         S_RUN:   if (disp_ok && last_pixel) state_nxt = S_DRAIN;
         S_DRAIN: if (all_free) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x    <= '0;
         y    <= '0;
         addr <= '0;
         re   <= '0;
         im   <= '0;
      end else if (state == S_IDLE && frame_start) begin
         x    <= '0;
         y    <= '0;
         addr <= '0;
         re   <= X_START;
         im   <= Y_START;
      end else if (disp_ok) begin
         addr <= addr + 1'b1;
         if (x == X_LAST) begin
            x  <= '0;
            re <= X_START;
            y  <= y + 1'b1;
            im <= im + Y_STEP;
         end else begin
            x  <= x + 1'b1;
            re <= re + X_STEP;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         core_start <= '0;
         wr_lock    <= 1'b0;
         wr_sel     <= '0;
         rr_ptr     <= '0;
         for (int unsigned i = 0; i < NUM_CORES; i++) begin
            slot_st[i]     <= SLOT_FREE;
            slot_addr[i]   <= '0;
            slot_re[i]     <= '0;
            slot_im[i]     <= '0;
            slot_colour[i] <= '0;
            slot_hold[i]   <= '0;
         end
      end else begin
         core_start <= '0;
         if (wr_done) begin
            wr_lock <= 1'b0;
            rr_ptr  <= (sel == C_LAST) ? '0 : sel + 1'b1;
         end else if (wr_valid) begin
            wr_lock <= 1'b1;
            wr_sel  <= sel;
         end
         for (int unsigned i = 0; i < NUM_CORES; i++) begin
            case (slot_st[i])
               SLOT_FREE: begin
                  if (disp_ok && disp_idx == CW'(i)) begin
                     slot_st[i]    <= SLOT_BUSY;
                     slot_addr[i]  <= addr;
                     slot_re[i]    <= re;
                     slot_im[i]    <= im;
                     slot_hold[i]  <= 2'd2;
                     core_start[i] <= 1'b1;
                  end
               end
               // Output-ready is blind during the start cycle and the one after.
               SLOT_BUSY: begin
                  if (slot_hold[i] != 2'd0) begin
                     slot_hold[i] <= slot_hold[i] - 2'd1;
                  end else if (core_out_ready[i]) begin
                     slot_colour[i] <= core_colour[i*BIT_WIDTH +: BIT_WIDTH];
                     slot_st[i]     <= SLOT_RESULT;
                  end
               end
               SLOT_RESULT: begin
                  if (wr_done && sel == CW'(i)) slot_st[i] <= SLOT_FREE;
               end
               default: slot_st[i] <= SLOT_FREE;
            endcase
         end
      end
   end

endmodule
